// File: rtl/mmio_bridge_pkg.sv
// Shared types and defaults for the MCS I/O to MMIO slot bus bridge.
package mmio_bridge_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} bridge_state_t;
  localparam logic [1:0]  MMIO_REGION  = 2'b11;
  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;
endpackage

// File: rtl/io_mmio_bridge_ws.sv
// MCS I/O bus to MMIO slot bus bridge: one outstanding request, variable-latency
// slaves via ack, wait-state timeout, sticky error/overrun flags and error count.
module io_mmio_bridge_ws
  import mmio_bridge_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 21,
  parameter logic [1:0]        REGION_HI = MMIO_REGION,
  parameter int                TIMEOUT   = 255,
  parameter logic [DATA_W-1:0] ERR_DATA  = DATA_W'(ERR_DATA_DEF)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_io_addr_strobe,
  input  logic                  i_io_read_strobe,
  input  logic                  i_io_write_strobe,
  input  logic [DATA_W/8-1:0]   i_io_byte_enable,
  input  logic [31:0]           i_io_address,
  input  logic [DATA_W-1:0]     i_io_write_data,
  output logic [DATA_W-1:0]     o_io_read_data,
  output logic                  o_io_ready,
  output logic                  o_mmio_cs,
  output logic                  o_mmio_read,
  output logic                  o_mmio_write,
  output logic [DATA_W/8-1:0]   o_mmio_be,
  output logic [ADDR_W-1:0]     o_mmio_addr,
  output logic [DATA_W-1:0]     o_mmio_write_data,
  input  logic [DATA_W-1:0]     i_mmio_read_data,
  input  logic                  i_mmio_ack,
  input  logic                  i_err_clr,
  output logic                  o_busy,
  output logic                  o_err,
  output logic                  o_overrun,
  output logic [7:0]            o_err_cnt
);
  localparam int TW = $clog2(TIMEOUT + 1);

  bridge_state_t state;
  logic [TW-1:0] timer;
  logic          is_rd;
  logic          start, in_region, timed_out, err_event, overrun_event;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_io_address[29:ADDR_W+2], i_io_address[1:0]};

  assign start         = i_io_addr_strobe && (i_io_read_strobe ^ i_io_write_strobe);
  assign in_region     = (i_io_address[31:30] == REGION_HI);
  assign timed_out     = (state == WAIT) && !i_mmio_ack && (timer == TW'(TIMEOUT));
  assign err_event     = ((state == IDLE) && start && !in_region) || timed_out;
  assign overrun_event = i_io_addr_strobe && (state != IDLE);
  assign o_busy        = (state != IDLE);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state             <= IDLE;
      timer             <= '0;
      is_rd             <= 1'b0;
      o_io_read_data    <= '0;
      o_io_ready        <= 1'b0;
      o_mmio_cs         <= 1'b0;
      o_mmio_read       <= 1'b0;
      o_mmio_write      <= 1'b0;
      o_mmio_be         <= '0;
      o_mmio_addr       <= '0;
      o_mmio_write_data <= '0;
    end else begin
      o_io_ready     <= 1'b0;
      o_io_read_data <= '0;
      o_mmio_cs      <= 1'b0;
      o_mmio_read    <= 1'b0;
      o_mmio_write   <= 1'b0;
      o_mmio_be      <= '0;
      unique case (state)
        IDLE: if (start) begin
          o_mmio_addr       <= i_io_address[ADDR_W+1:2];
          o_mmio_write_data <= i_io_write_data;
          is_rd             <= i_io_read_strobe;
          if (!in_region) begin
            state          <= RESP;
            o_io_ready     <= 1'b1;
            o_io_read_data <= ERR_DATA;
          end else begin
            state        <= REQ;
            o_mmio_cs    <= 1'b1;
            o_mmio_read  <= i_io_read_strobe;
            o_mmio_write <= i_io_write_strobe;
            o_mmio_be    <= i_io_byte_enable;
          end
        end
        REQ: begin
          timer <= '0;
          if (i_mmio_ack) begin
            state          <= RESP;
            o_io_ready     <= 1'b1;
            o_io_read_data <= is_rd ? i_mmio_read_data : '0;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          // A late ack arriving on the timeout cycle still completes cleanly.
          if (i_mmio_ack) begin
            state          <= RESP;
            o_io_ready     <= 1'b1;
            o_io_read_data <= is_rd ? i_mmio_read_data : '0;
          end else if (timed_out) begin
            state          <= RESP;
            o_io_ready     <= 1'b1;
            o_io_read_data <= ERR_DATA;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Clear and a new error in the same cycle: the new error survives.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_err     <= 1'b0;
      o_overrun <= 1'b0;
      o_err_cnt <= '0;
    end else begin
      if (i_err_clr) begin
        o_err     <= err_event;
        o_overrun <= overrun_event;
        o_err_cnt <= err_event ? 8'd1 : 8'd0;
      end else begin
        o_err     <= o_err | err_event;
        o_overrun <= o_overrun | overrun_event;
        if (err_event && o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
      end
    end
  end
endmodule
